// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: cache requests, main-memory port and cache-fill signals of the fill controller
interface cache_fill_ctrl_if;
    logic        I_miss;
    logic        D_miss;
    logic        D_write_req;
    logic [15:0] I_addr;
    logic [15:0] D_addr;
    logic [15:0] D_wdata;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_offset;
    logic        I_data_we;
    logic        D_data_we;
    logic        I_tag_we;
    logic        D_tag_we;
    logic        I_stall;
    logic        D_stall;
    logic        busy;

    modport master (
        input  I_miss, D_miss, D_write_req, I_addr, D_addr, D_wdata, mem_data_out, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_offset,
               I_data_we, D_data_we, I_tag_we, D_tag_we, I_stall, D_stall, busy
    );

    modport slave (
        output I_miss, D_miss, D_write_req, I_addr, D_addr, D_wdata, mem_data_out, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_offset,
               I_data_we, D_data_we, I_tag_we, D_tag_we, I_stall, D_stall, busy
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: arbitrates the memory port between I/D block fills and D write-through stores
module cache_fill_ctrl #(
    parameter int WORDS = 8
) (
    input logic              clk,
    input logic              rst,
    cache_fill_ctrl_if.master bus
);
    localparam int OW = $clog2(WORDS);
    localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t        r_state, w_state_nx;
    logic          r_src, w_src_nx;
    logic [15:0]   r_base, w_base_nx;
    logic [OW:0]   r_issue_cnt, w_issue_nx;
    logic [OW-1:0] r_recv_cnt, w_recv_nx;
    logic          w_fill, w_write, w_issue, w_we, w_last;

    assign w_fill  = r_state == FILL;
    assign w_write = r_state == WRITE;
    assign w_issue = w_fill & ~r_issue_cnt[OW];
    assign w_we    = w_fill & bus.mem_data_valid;
    assign w_last  = w_we & (r_recv_cnt == OW'(WORDS - 1));

    // state, requester (1 = D-cache), block base and issue/receive counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_src       <= 1'b0;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_src       <= w_src_nx;
            r_base      <= w_base_nx;
            r_issue_cnt <= w_issue_nx;
            r_recv_cnt  <= w_recv_nx;
        end
    end

    // fixed-priority arbitration in IDLE; a fill ends on its last returned word
    always_comb begin
        w_state_nx = r_state;
        w_src_nx   = r_src;
        w_base_nx  = r_base;
        w_issue_nx = r_issue_cnt + {{OW{1'b0}}, w_issue};
        w_recv_nx  = r_recv_cnt + {{(OW-1){1'b0}}, w_we};
        case (r_state)
            IDLE: begin
                if (bus.I_miss | bus.D_miss) begin
                    w_state_nx = FILL;
                    w_src_nx   = ~bus.I_miss;
                    w_base_nx  = (bus.I_miss ? bus.I_addr : bus.D_addr) & BLK_MASK;
                    w_issue_nx = '0;
                    w_recv_nx  = '0;
                end else if (bus.D_write_req) begin
                    w_state_nx = WRITE;
                end
            end
            FILL:    w_state_nx = w_last ? IDLE : FILL;
            default: w_state_nx = IDLE;
        endcase
    end

    // memory port, cache fill strobes and pipeline stalls
    always_comb begin
        bus.mem_en      = w_issue | w_write;
        bus.mem_wr      = w_write;
        bus.mem_addr    = w_write ? bus.D_addr : w_issue ? r_base + 16'({r_issue_cnt[OW-1:0], 1'b0}) : '0;
        bus.mem_data_in = w_write ? bus.D_wdata : '0;
        bus.fill_data   = w_we ? bus.mem_data_out : '0;
        bus.fill_offset = w_we ? 3'(r_recv_cnt) : '0;
        bus.I_data_we   = w_we & ~r_src;
        bus.D_data_we   = w_we & r_src;
        bus.I_tag_we    = w_last & ~r_src;
        bus.D_tag_we    = w_last & r_src;
        bus.I_stall     = bus.I_miss | (w_fill & ~r_src);
        bus.D_stall     = bus.D_miss | (w_fill & r_src) | (bus.D_write_req & ~w_write);
        bus.busy        = r_state != IDLE;
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: directed vectors and fill/store sequences against a 4-cycle pipelined memory model
module tb_cache_fill_ctrl;
    logic clk, rst;
    int errs = 0;
    int checks = 0;
    cache_fill_ctrl_if bus ();

    cache_fill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: read issued in cycle c returns in cycle c+4 with data mem_base + word index
    logic [15:0] mem_base;
    logic        force_valid;
    logic [3:0]  pv;
    logic [15:0] pd [4];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else pv <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
        pd[0] <= mem_base + 16'(bus.mem_addr[3:1]);
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign bus.mem_data_valid = pv[3] | force_valid;
    assign bus.mem_data_out   = pd[3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [58:0] pk(logic en, logic wr, logic [15:0] addr, logic [15:0] din,
                                       logic idwe, logic ddwe, logic [2:0] off, logic [15:0] fd,
                                       logic itag, logic dtag, logic ist, logic dst, logic bsy);
        return {en, wr, addr, din, idwe, ddwe, off, fd, itag, dtag, ist, dst, bsy};
    endfunction

    function automatic logic [58:0] snap();
        return pk(bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.I_data_we, bus.D_data_we,
                  bus.fill_offset, bus.fill_data, bus.I_tag_we, bus.D_tag_we, bus.I_stall, bus.D_stall, bus.busy);
    endfunction

    // expected outputs k cycles after a miss is seen in IDLE
    function automatic logic [58:0] fexp(int k, logic d, logic [15:0] base, logic [15:0] dbase,
                                         logic ist, logic dst);
        logic en, we, bsy;
        en  = k >= 1 && k <= 8;
        we  = k >= 5 && k <= 12;
        bsy = k >= 1 && k <= 12;
        return pk(en, 1'b0, en ? base + 16'(2 * (k - 1)) : 16'h0, 16'h0, we & ~d, we & d,
                  we ? 3'(k - 5) : 3'h0, we ? dbase + 16'(k - 5) : 16'h0,
                  (k == 12) & ~d, (k == 12) & d, ist | (bsy & ~d), dst | (bsy & d), bsy);
    endfunction

    task automatic chk(input string nm, input logic [58:0] act, input logic [58:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic im, dm, dw, dv;
        logic is0, ds0;
        logic busy1, en1, wr1;
        logic [15:0] addr1, din1;
        logic is1, ds1;
    } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{0,0,0,0, 0,0, 0,0,0, 16'h0000,16'h0000, 0,0};
        tbl[1] = '{1,0,0,0, 1,0, 1,1,0, 16'h1230,16'h0000, 1,0};
        tbl[2] = '{0,1,0,0, 0,1, 1,1,0, 16'h8000,16'h0000, 0,1};
        tbl[3] = '{0,0,1,0, 0,1, 1,1,1, 16'h8008,16'h5555, 0,0};
        tbl[4] = '{1,1,0,0, 1,1, 1,1,0, 16'h1230,16'h0000, 1,1};
        tbl[5] = '{0,1,1,0, 0,1, 1,1,0, 16'h8000,16'h0000, 0,1};
        tbl[6] = '{1,0,1,0, 1,1, 1,1,0, 16'h1230,16'h0000, 1,1};
        tbl[7] = '{0,0,0,1, 0,0, 0,0,0, 16'h0000,16'h0000, 0,0};
        rst = 1'b1;
        force_valid = 1'b0;
        mem_base = 16'hA000;
        bus.I_miss = 1'b0;
        bus.D_miss = 1'b0;
        bus.D_write_req = 1'b0;
        bus.I_addr = 16'h0;
        bus.D_addr = 16'h0;
        bus.D_wdata = 16'h0;
        tick();
        tick();
        chk("reset", snap(), '0);
        // arbitration vectors: cycle 0 in IDLE, cycle 1 shows the granted access, then reset
        bus.I_addr = 16'h1236;
        bus.D_addr = 16'h8008;
        bus.D_wdata = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            tick();
            rst = 1'b0;
            bus.I_miss = tbl[i].im;
            bus.D_miss = tbl[i].dm;
            bus.D_write_req = tbl[i].dw;
            force_valid = tbl[i].dv;
            #1;
            chk($sformatf("vec%0d c0", i), snap(), pk(0,0,0,0,0,0,0,0,0,0, tbl[i].is0, tbl[i].ds0, 0));
            tick();
            force_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d c1", i), snap(), pk(tbl[i].en1, tbl[i].wr1, tbl[i].addr1, tbl[i].din1,
                0,0,0,0,0,0, tbl[i].is1, tbl[i].ds1, tbl[i].busy1));
            tick();
            bus.I_miss = 1'b0;
            bus.D_miss = 1'b0;
            bus.D_write_req = 1'b0;
            rst = 1'b1;
        end
        tick();
        rst = 1'b0;
        // I miss at 0x1236: reads 1..8, data 5..12, tag at 12
        mem_base = 16'hA000;
        for (int c = 0; c <= 13; c++) begin
            tick();
            if (c == 0) begin bus.I_miss = 1'b1; bus.I_addr = 16'h1236; end
            if (c == 13) bus.I_miss = 1'b0;
            #1;
            chk($sformatf("imiss c%0d", c), snap(), fexp(c, 0, 16'h1230, 16'hA000, c <= 12, 0));
        end
        // simultaneous misses: I block first, D fill starts right after the I tag write
        mem_base = 16'h1000;
        for (int c = 0; c <= 26; c++) begin
            tick();
            if (c == 0) begin
                bus.I_miss = 1'b1; bus.I_addr = 16'h0040;
                bus.D_miss = 1'b1; bus.D_addr = 16'h8008;
            end
            if (c == 13) begin bus.I_miss = 1'b0; mem_base = 16'h2000; end
            if (c == 26) bus.D_miss = 1'b0;
            #1;
            if (c <= 12) chk($sformatf("both c%0d", c), snap(), fexp(c, 0, 16'h0040, 16'h1000, 1, 1));
            else chk($sformatf("both c%0d", c), snap(), fexp(c - 13, 1, 16'h8000, 16'h2000, 0, c <= 25));
        end
        // store hit, then a back-to-back store
        tick();
        bus.D_write_req = 1'b1; bus.D_addr = 16'h2002; bus.D_wdata = 16'hBEEF;
        #1;
        chk("st c0", snap(), pk(0,0,0,0,0,0,0,0,0,0,0,1,0));
        tick();
        chk("st c1", snap(), pk(1,1,16'h2002,16'hBEEF,0,0,0,0,0,0,0,0,1));
        tick();
        bus.D_addr = 16'h2004; bus.D_wdata = 16'h1234;
        #1;
        chk("st c2", snap(), pk(0,0,0,0,0,0,0,0,0,0,0,1,0));
        tick();
        chk("st c3", snap(), pk(1,1,16'h2004,16'h1234,0,0,0,0,0,0,0,0,1));
        tick();
        bus.D_write_req = 1'b0;
        #1;
        chk("st c4", snap(), '0);
        // store miss at 0x3004: fill 0x3000 block, then write-through
        mem_base = 16'hB000;
        for (int c = 0; c <= 15; c++) begin
            tick();
            if (c == 0) begin
                bus.D_miss = 1'b1; bus.D_write_req = 1'b1;
                bus.D_addr = 16'h3004; bus.D_wdata = 16'h7777;
            end
            if (c == 13) bus.D_miss = 1'b0;
            if (c == 15) bus.D_write_req = 1'b0;
            #1;
            if (c <= 13) chk($sformatf("stmiss c%0d", c), snap(), fexp(c, 1, 16'h3000, 16'hB000, 0, c <= 14));
            else if (c == 14) chk("stmiss c14", snap(), pk(1,1,16'h3004,16'h7777,0,0,0,0,0,0,0,0,1));
            else chk("stmiss c15", snap(), '0);
        end
        // reset in cycle 6 of a fill, spurious valids after it, then a clean fill
        mem_base = 16'hA000;
        for (int c = 0; c <= 9; c++) begin
            tick();
            if (c == 0) begin bus.I_miss = 1'b1; bus.I_addr = 16'h5678; end
            if (c == 6) rst = 1'b1;
            if (c == 7) begin rst = 1'b0; bus.I_miss = 1'b0; force_valid = 1'b1; end
            if (c == 9) force_valid = 1'b0;
            #1;
            if (c <= 6) chk($sformatf("rstfill c%0d", c), snap(), fexp(c, 0, 16'h5670, 16'hA000, 1, 0));
            else chk($sformatf("rstfill c%0d", c), snap(), '0);
        end
        mem_base = 16'hD000;
        for (int c = 0; c <= 13; c++) begin
            tick();
            if (c == 0) bus.I_miss = 1'b1;
            if (c == 13) bus.I_miss = 1'b0;
            #1;
            chk($sformatf("refill c%0d", c), snap(), fexp(c, 0, 16'h5670, 16'hD000, c <= 12, 0));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Fill controller and memory arbiter for the split I-cache / D-cache of the 16-bit pipeline. It owns the single pipelined main-memory port and grants it to one of three requesters: an I-cache miss, a D-cache miss, or a D-cache write-through store. For a miss it streams one 8-word (16-byte) block into the requesting cache and writes the tag on the last word. It produces the pipeline stall signals.

## Interface
- WORDS: default 8; words per cache block (offset counter is 3 bits).
- MEM_LAT: default 4; cycles from read issue to `mem_data_valid`.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- I_miss  in  1  I-cache miss for `I_addr`; held until the tag is written.
- D_miss  in  1  D-cache miss for `D_addr`; held until the tag is written.
- D_write_req  in  1  store hitting or missing D-cache; needs a write-through.
- I_addr  in  16  PC (byte address).
- D_addr  in  16  data byte address.
- D_wdata  in  16  store data.
- mem_data_out  in  16  read data from memory.
- mem_data_valid  in  1  `mem_data_out` valid this cycle.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read; meaningful only with `mem_en`.
- mem_addr  out  16  memory byte address.
- mem_data_in  out  16  write data; 0 when `mem_wr` = 0.
- fill_data  out  16  word to cache data array (= `mem_data_out`).
- fill_offset  out  3  word index within block for `fill_data`.
- I_data_we, D_data_we  out  1  data-array word write enable.
- I_tag_we, D_tag_we  out  1  tag/valid write enable.
- I_stall, D_stall  out  1  freeze the fetch stage / memory stage.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, FILL, WRITE.
- IDLE arbitration, fixed priority: `I_miss` > `D_miss` > `D_write_req`.
  - Miss: latch `src` (I or D) and `base = addr & 16'hFFF0`. Clear `issue_cnt` and `recv_cnt`. Go to FILL.
  - Store only: go to WRITE.
- FILL, issue:
  - While `issue_cnt < 8`: `mem_en=1`, `mem_wr=0`, `mem_addr = base + 2*issue_cnt`.
  - `issue_cnt` increments each cycle. One read per cycle, no gaps.
- FILL, receive:
  - On each `mem_data_valid`: assert `{src}_data_we`, with `fill_offset = recv_cnt` and `fill_data = mem_data_out`. Then `recv_cnt` increments.
  - On the valid with `recv_cnt == 7`: also assert `{src}_tag_we` in the same cycle, then go to IDLE.
- WRITE lasts one cycle: `mem_en=1`, `mem_wr=1`, `mem_addr=D_addr`, `mem_data_in=D_wdata`. Then go to IDLE.
- Store that misses (`D_miss` and `D_write_req`): the fill runs first. `D_miss` drops after the tag write, and the next IDLE cycle starts WRITE (write-allocate, then write-through).
- Stalls (combinational):
  - `I_stall = I_miss | (FILL & src==I)`.
  - `D_stall = D_miss | (FILL & src==D) | (D_write_req & state!=WRITE)`.
  - So a store stalls in its IDLE cycle and is released in its WRITE cycle.
- `mem_data_valid` outside FILL is ignored. No cache write enables are asserted outside FILL.
- Both misses at once: the I block is filled first. `D_miss` stays high, so the D fill starts in the IDLE cycle after the I tag write.

## Timing
- Reset, synchronous, takes effect at the next edge from any state:
  - State goes to IDLE; counters and `src` clear.
  - All outputs are 0 except stalls, which follow their combinational inputs.
  - Reset mid-FILL abandons the fill with no tag write.
  - Memory shares `rst`, so no stale returns occur.
- Miss timing, miss seen in IDLE at cycle 0:
  - Reads issued cycles 1..8.
  - Data valid cycles 5..12 (MEM_LAT = 4).
  - Tag write in cycle 12; IDLE in cycle 13.
  - Total miss penalty is 13 cycles; I_miss/D_miss drop in cycle 13 from the cache.
- Store: request seen in IDLE at cycle 0, WRITE in cycle 1, back to IDLE in cycle 2. A back-to-back store costs 2 cycles.
- Address arithmetic is 16-bit. `base + 14` never crosses a block, so there is no wrap.
- `busy` is high exactly in FILL and WRITE.

## Test plan
- I miss, `I_addr=16'h1236`:
  - Reads to 0x1230..0x123E in cycles 1..8.
  - Memory returns 0xA000+i; `I_data_we` with offsets 0..7 and data 0xA000..0xA007 in cycles 5..12.
  - `I_tag_we` in cycle 12; `I_stall` low in cycle 13.
- Simultaneous `I_miss` (0x0040) and `D_miss` (0x8008):
  - I block 0x0040..0x004E filled and tagged first.
  - D fill starts in the cycle after; reads 0x8000..0x800E.
  - `D_stall` is high throughout.
- Store hit, `D_addr=16'h2002`, `D_wdata=16'hBEEF`: cycle 1 has `mem_en=1`, `mem_wr=1`, addr 0x2002, data 0xBEEF. `D_stall` is 1 in cycle 0 and 0 in cycle 1.
- Store miss to 0x3004: 8-word fill of 0x3000 block with `D_tag_we`, then a WRITE cycle to 0x3004. No write is issued before the tag write.
- Reset asserted in cycle 6 of a fill:
  - Next cycle: IDLE, no `*_tag_we`, later `mem_data_valid` pulses produce no write enables.
  - A new miss afterwards gets a full, correct fill.
- Spurious `mem_data_valid` in IDLE with no requests: all outputs remain 0.
